// File: rtl/msrv32_wb_pkg.sv
// msrv32_wb_pkg: write-back source indices and stage state encoding
package msrv32_wb_pkg;
  localparam int WB_ALU     = 0;
  localparam int WB_LU      = 1;
  localparam int WB_IMM     = 2;
  localparam int WB_IADDER  = 3;
  localparam int WB_CSR     = 4;
  localparam int WB_PC_PLUS = 5;
  typedef enum logic {WB_IDLE, WB_WAIT_LU} wb_state_e;
endpackage

// File: rtl/msrv32_wb_src_sel.sv
// msrv32_wb_src_sel: NSRC:1 result select, load slot taken from the load unit, out-of-range falls back to ALU
module msrv32_wb_src_sel
  import msrv32_wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 8,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [SELW-1:0]      sel,
  input  logic [NSRC*XLEN-1:0] src_bus,
  input  logic [XLEN-1:0]      lu_data,
  output logic [XLEN-1:0]      data
);
  always_comb begin
    data = (int'(sel) < NSRC) ? src_bus[int'(sel)*XLEN +: XLEN] : src_bus[WB_ALU*XLEN +: XLEN];
    data = (sel == SELW'(WB_LU)) ? lu_data : data;
  end
endmodule

// File: rtl/msrv32_wb_stage.sv
// msrv32_wb_stage: registered write-back stage that stalls for late load data; MSRV32_WB_FWD_EN adds forwarding ports
module msrv32_wb_stage
  import msrv32_wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 8,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 wb_valid_in,
  output logic                 wb_ready_out,
  input  logic [SELW-1:0]      wb_mux_sel_in,
  input  logic [4:0]           rd_addr_in,
  input  logic                 rf_wr_en_in,
  input  logic [NSRC*XLEN-1:0] src_bus_in,
  input  logic                 lu_valid_in,
  input  logic [XLEN-1:0]      lu_output_in,
  input  logic                 flush_in,
  output logic                 rf_wr_en_out,
  output logic [4:0]           rf_rd_addr_out,
  output logic [XLEN-1:0]      rf_wr_data_out,
`ifdef MSRV32_WB_FWD_EN
  input  logic [4:0]           rs1_addr_in,
  input  logic [4:0]           rs2_addr_in,
  output logic                 fwd_rs1_hit_out,
  output logic                 fwd_rs2_hit_out,
  output logic [XLEN-1:0]      fwd_data_out,
`endif
  output logic                 wb_busy_out
);
  wb_state_e       state, next_state;
  logic [XLEN-1:0] sel_data, wr_data;
  logic [4:0]      pend_rd, wr_rd;
  logic            pend_en, wr_flag, accept, load_sel, lu_cap, wr_now;
  msrv32_wb_src_sel #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW)) u_src_sel (
    .sel(wb_mux_sel_in),
    .src_bus(src_bus_in),
    .lu_data(lu_output_in),
    .data(sel_data)
  );
  assign wb_ready_out = state == WB_IDLE;
  assign wb_busy_out  = state == WB_WAIT_LU;
  always_comb begin
    accept     = wb_valid_in & wb_ready_out & ~flush_in;
    load_sel   = wb_mux_sel_in == SELW'(WB_LU);
    lu_cap     = wb_busy_out & lu_valid_in & ~flush_in;
    wr_now     = (accept & (~load_sel | lu_valid_in)) | lu_cap;
    wr_data    = lu_cap ? lu_output_in : sel_data;
    wr_rd      = lu_cap ? pend_rd : rd_addr_in;
    wr_flag    = lu_cap ? pend_en : rf_wr_en_in;
    next_state = wb_busy_out ? ((flush_in | lu_valid_in) ? WB_IDLE : WB_WAIT_LU)
                             : ((accept & load_sel & ~lu_valid_in) ? WB_WAIT_LU : WB_IDLE);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= WB_IDLE;
      rf_wr_en_out   <= 1'b0;
      rf_rd_addr_out <= '0;
      rf_wr_data_out <= '0;
      pend_rd        <= '0;
      pend_en        <= 1'b0;
    end else begin
      state        <= next_state;
      rf_wr_en_out <= wr_now & wr_flag & (wr_rd != 5'd0);
      if (wr_now) begin
        rf_rd_addr_out <= wr_rd;
        rf_wr_data_out <= wr_data;
      end
      if (accept & load_sel & ~lu_valid_in) begin
        pend_rd <= rd_addr_in;
        pend_en <= rf_wr_en_in;
      end
    end
  end
`ifdef MSRV32_WB_FWD_EN
  assign fwd_rs1_hit_out = rf_wr_en_out & (rs1_addr_in != 5'd0) & (rs1_addr_in == rf_rd_addr_out);
  assign fwd_rs2_hit_out = rf_wr_en_out & (rs2_addr_in != 5'd0) & (rs2_addr_in == rf_rd_addr_out);
  assign fwd_data_out    = rf_wr_data_out;
`endif
endmodule

// File: tb/tb_msrv32_wb_stage.sv
// tb_msrv32_wb_stage: directed plus randomized checks of the write-back stage against a transaction-level model
module tb_msrv32_wb_stage;
  localparam int XLEN = 32;
  localparam int NSRC = 6;
  localparam int SELW = 3;
  logic                 clk = 0;
  logic                 rst_in = 1;
  logic                 wb_valid_in = 0;
  logic                 wb_ready_out;
  logic [SELW-1:0]      wb_mux_sel_in = 0;
  logic [4:0]           rd_addr_in = 0;
  logic                 rf_wr_en_in = 0;
  logic [NSRC*XLEN-1:0] src_bus_in = '0;
  logic                 lu_valid_in = 0;
  logic [XLEN-1:0]      lu_output_in = 0;
  logic                 flush_in = 0;
  logic                 rf_wr_en_out;
  logic [4:0]           rf_rd_addr_out;
  logic [XLEN-1:0]      rf_wr_data_out;
  logic                 wb_busy_out;
`ifdef MSRV32_WB_FWD_EN
  logic [4:0]           rs1_addr_in = 0, rs2_addr_in = 0;
  logic                 fwd_rs1_hit_out, fwd_rs2_hit_out;
  logic [XLEN-1:0]      fwd_data_out;
`endif
  int n_vec = 0, n_bad = 0;
  bit waiting = 0, p_en = 0, exp_en = 0;
  logic [4:0]      p_rd = 0, exp_addr = 0;
  logic [XLEN-1:0] exp_data = 0;
  int stall_cycles = 0;

  msrv32_wb_stage #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW)) dut (
    .clk_in(clk), .rst_in(rst_in), .wb_valid_in(wb_valid_in), .wb_ready_out(wb_ready_out),
    .wb_mux_sel_in(wb_mux_sel_in), .rd_addr_in(rd_addr_in), .rf_wr_en_in(rf_wr_en_in),
    .src_bus_in(src_bus_in), .lu_valid_in(lu_valid_in), .lu_output_in(lu_output_in),
    .flush_in(flush_in), .rf_wr_en_out(rf_wr_en_out), .rf_rd_addr_out(rf_rd_addr_out),
    .rf_wr_data_out(rf_wr_data_out),
`ifdef MSRV32_WB_FWD_EN
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .fwd_rs1_hit_out(fwd_rs1_hit_out),
    .fwd_rs2_hit_out(fwd_rs2_hit_out), .fwd_data_out(fwd_data_out),
`endif
    .wb_busy_out(wb_busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] src_val(input int sel);
    if (sel == 1) return lu_output_in;
    if (sel >= NSRC) return src_bus_in[31:0];
    return src_bus_in[sel*XLEN +: XLEN];
  endfunction

  task automatic set_src(input int k, input logic [XLEN-1:0] v);
    src_bus_in[k*XLEN +: XLEN] = v;
  endtask

  // Applies the current inputs for one clock, advances the model and checks outputs 1 time unit after the edge.
  task automatic tick();
    bit wr, w_en;
    logic [4:0] w_rd;
    logic [XLEN-1:0] w_data;
    wr = 0; w_en = 0; w_rd = 0; w_data = 0;
    if (!rst_in) begin
      check("ready", wb_ready_out, !waiting);
      check("busy", wb_busy_out, waiting);
    end
    if (rst_in) begin
      waiting = 0; exp_en = 0; exp_addr = 0; exp_data = 0;
    end else begin
      if (wb_valid_in && !waiting && !flush_in) begin
        if (wb_mux_sel_in == 1 && !lu_valid_in) begin
          waiting = 1; p_rd = rd_addr_in; p_en = rf_wr_en_in;
        end else begin
          wr = 1; w_rd = rd_addr_in; w_en = rf_wr_en_in; w_data = src_val(int'(wb_mux_sel_in));
        end
      end else if (waiting && flush_in) waiting = 0;
      else if (waiting && lu_valid_in) begin
        waiting = 0; wr = 1; w_rd = p_rd; w_en = p_en; w_data = lu_output_in;
      end
      exp_en = wr && w_en && w_rd != 0;
      if (wr) begin exp_addr = w_rd; exp_data = w_data; end
    end
    @(posedge clk);
    #1;
    check("wr_en", rf_wr_en_out, exp_en);
    check("addr", rf_rd_addr_out, exp_addr);
    check("data", rf_wr_data_out, exp_data);
`ifdef MSRV32_WB_FWD_EN
    check("rs1_hit", fwd_rs1_hit_out, exp_en && rs1_addr_in != 0 && rs1_addr_in == exp_addr);
    check("rs2_hit", fwd_rs2_hit_out, exp_en && rs2_addr_in != 0 && rs2_addr_in == exp_addr);
    check("fwd_data", fwd_data_out, exp_data);
`endif
  endtask

  task automatic drive(input bit v, input int sel, input int rd, input bit en, input bit luv,
                       input logic [XLEN-1:0] lu, input bit fl);
    wb_valid_in = v; wb_mux_sel_in = SELW'(sel); rd_addr_in = 5'(rd); rf_wr_en_in = en;
    lu_valid_in = luv; lu_output_in = lu; flush_in = fl;
    tick();
  endtask

  initial begin
    rst_in = 1;
    tick();
    tick();
    rst_in = 0;
    check("ready_after_rst", wb_ready_out, 1);
    for (int k = 0; k < NSRC; k++) set_src(k, 32'h100 * k + 32'h11);
    set_src(0, 32'h1234); set_src(2, 32'h55); set_src(4, 32'hA); set_src(5, 32'h104);
    drive(1, 0, 5, 1, 0, 0, 0);
    check("alu_wr", {rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out[15:0]}, {1'b1, 5'd5, 16'h1234});
    drive(0, 0, 0, 0, 0, 0, 0);
    check("alu_done", rf_wr_en_out, 0);
    drive(1, 4, 9, 1, 0, 0, 0);
    drive(1, 5, 10, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stall_cycles += int'(wb_busy_out);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    check("stall_cycles", stall_cycles, 3);
    drive(0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    check("load_wr", {rf_wr_en_out, rf_rd_addr_out}, {1'b1, 5'd7});
    check("load_data", rf_wr_data_out, 32'hDEADBEEF);
    drive(1, 1, 8, 1, 0, 0, 0);
    drive(1, 0, 9, 1, 0, 0, 1);
    check("flush_idle", wb_ready_out, 1);
    drive(0, 0, 0, 0, 1, 32'hCAFE, 0);
    check("lu_ignored", rf_wr_en_out, 0);
    drive(1, 2, 0, 1, 0, 0, 0);
    check("x0_addr", rf_rd_addr_out, 0);
    drive(1, 7, 12, 1, 0, 0, 0);
    check("oor_alu", rf_wr_data_out, 32'h1234);
    drive(1, 1, 13, 1, 1, 32'h7777, 0);
    drive(1, 1, 14, 1, 0, 0, 0);
    rst_in = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_in = 0;
    drive(0, 0, 0, 0, 1, 32'h9999, 0);
    check("rst_drop_load", rf_wr_en_out, 0);
`ifdef MSRV32_WB_FWD_EN
    rs1_addr_in = 3; rs2_addr_in = 0;
    drive(1, 0, 3, 1, 0, 0, 0);
`endif
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NSRC; k++) set_src(k, $urandom);
      rst_in = ($urandom_range(0, 60) == 0);
`ifdef MSRV32_WB_FWD_EN
      rs1_addr_in = 5'($urandom_range(0, 7)); rs2_addr_in = 5'($urandom_range(0, 7));
`endif
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/msrv32_wb_stage.md
# msrv32_wb_stage

Parametrised, registered write-back stage for the msrv32 pipeline. It selects one of `NSRC` result sources and handles loads whose data arrives later than the instruction. It drives the register-file write port through an output register. A valid/ready handshake lets the stage stall the upstream pipeline while it waits for load data.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NSRC`, 8, number of write-back sources; must be ≥ 6.
- `SELW`, `$clog2(NSRC)`, select width (derived).

Ports. One clock `clk_in`; reset `rst_in` is synchronous and active-high.
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous active-high reset.
- `wb_valid_in` in 1: instruction present upstream.
- `wb_ready_out` out 1: stage can accept this cycle.
- `wb_mux_sel_in` in SELW: source index.
- `rd_addr_in` in 5: destination register.
- `rf_wr_en_in` in 1: instruction writes `rd`.
- `src_bus_in` in NSRC*XLEN: source k at `[k*XLEN +: XLEN]`.
- `lu_valid_in` in 1: load-unit data valid.
- `lu_output_in` in XLEN: load-unit data.
- `flush_in` in 1: kill pending and incoming instruction.
- `rf_wr_en_out` out 1: register-file write strobe.
- `rf_rd_addr_out` out 5: write address.
- `rf_wr_data_out` out XLEN: write data.
- `wb_busy_out` out 1: high in WAIT_LU.
- `rs1_addr_in`, `rs2_addr_in` in 5: present only with `WB_FWD_EN`.
- `fwd_rs1_hit_out`, `fwd_rs2_hit_out` out 1: present only with `WB_FWD_EN`.
- `fwd_data_out` out XLEN: present only with `WB_FWD_EN`.

## Operation
- Fixed source map:
  - 0 ALU, 1 LU, 2 IMM, 3 IADDER, 4 CSR, 5 PC+4.
  - 6..NSRC-1 are extension sources.
  - Any select ≥ NSRC selects source 0.
  - Index 1 takes `lu_output_in`, never `src_bus_in`.
- States:
  - IDLE: `wb_ready_out`=1.
  - WAIT_LU: `wb_ready_out`=0, `wb_busy_out`=1.
- Accept occurs when `wb_valid_in & wb_ready_out & ~flush_in`.
- Non-load accept:
  - Selected source, `rd_addr_in` and write flag are registered.
  - Next cycle, `rf_wr_en_out` = `rf_wr_en_in & (rd≠0)` for exactly one cycle.
  - State stays IDLE.
- Load accept with `lu_valid_in`=1 in the same cycle: data is captured immediately, handled as non-load.
- Load accept with `lu_valid_in`=0:
  - `rd` and the flag are latched.
  - State goes to WAIT_LU.
  - `rf_wr_en_out` is 0 while waiting.
- In WAIT_LU, `lu_valid_in`=1 captures `lu_output_in`, returns to IDLE and writes in the next cycle.
- `lu_valid_in` in IDLE without a load accept is ignored.
- `flush_in` has priority over `lu_valid_in` and accept:
  - WAIT_LU returns to IDLE; no write.
  - An instruction presented in the same cycle is dropped.
  - A write already in the output register still completes.
- `rd`=x0: the strobe is suppressed, but data and address still register.
- Reset mid-WAIT_LU: return to IDLE; the pending load is discarded.
- No write is issued after reset until a new accept.

## Timing
- Reset values:
  - State IDLE.
  - `rf_wr_en_out`=0, `rf_rd_addr_out`=0, `rf_wr_data_out`=0.
  - `wb_busy_out`=0, `wb_ready_out`=1 in the cycle after reset.
  - Forwarding outputs 0.
- Latency:
  - Non-load: accept cycle N → write strobe in N+1.
  - Load: `lu_valid_in` at cycle M → strobe in M+1.
- Throughput: one non-load per cycle, back-to-back.
- `wb_ready_out` is a function of state only; it has no combinational path from `wb_valid_in`.
- The output register updates only on a write-causing event. When no write is pending, `rf_wr_en_out` drops to 0 and data/address hold.

## Configuration
- Macro `MSRV32_WB_FWD_EN`.
- When defined:
  - `fwd_rsX_hit_out` = `rf_wr_en_out & (rsX_addr_in≠0) & (rsX_addr_in==rf_rd_addr_out)`, combinational.
  - `fwd_data_out` = `rf_wr_data_out`.
- When undefined: the forwarding ports and logic are absent; the remaining behaviour is identical.

## Structure
- Package `msrv32_wb_pkg` holds:
  - Source-index localparams: `WB_ALU`=0, `WB_LU`=1, `WB_IMM`=2, `WB_IADDER`=3, `WB_CSR`=4, `WB_PC_PLUS`=5.
  - State enum `{WB_IDLE, WB_WAIT_LU}`.
- Sub-module `msrv32_wb_src_sel`: pure combinational NSRC:1 select with the out-of-range default. Instantiated once.

## Test plan
- Reset, then sel=0, rd=5, ALU=0x1234 accepted at cycle 3 → cycle 4: `rf_wr_en_out`=1, addr=5, data=0x1234; cycle 5: `rf_wr_en_out`=0.
- Back-to-back: sel=4 (CSR=0xA), then sel=5 (PC+4=0x104) on consecutive cycles → two consecutive strobes with 0xA then 0x104, `wb_ready_out` constantly 1.
- Load rd=7 with no data, then `lu_valid_in`=1 with 0xDEADBEEF three cycles later → ready=0 and busy=1 for 3 cycles, strobe one cycle after `lu_valid_in` with 0xDEADBEEF, addr 7.
- Load waiting, `flush_in`=1 with new valid sel=0 in the same cycle → no write ever for either instruction; IDLE next cycle; a later `lu_valid_in` is ignored.
- rd=0 with sel=2 (IMM=0x55) → `rf_wr_en_out` stays 0; sel=7 with NSRC=6 → ALU source selected.
- With `MSRV32_WB_FWD_EN`: write to rd=3 pending, `rs1_addr_in`=3, `rs2_addr_in`=0 → rs1 hit=1, rs2 hit=0, `fwd_data_out` = write data.
